// File: rtl/sr_ctrl_arbiter_if.sv
// sr_ctrl_arbiter_if -- bundle between requesters/SRFF and the SR control arbiter.
//   req     : per-requester operation request (level, held until done)
//   op      : per-requester operation, 1 = set, 0 = clear
//   q       : feedback from the controlled SRFF output
//   err_clr : clears the sticky feedback error
//   S, R    : set / reset drive to the SRFF
//   gnt     : one-hot grant, zero when idle
//   done    : one-cycle completion pulse to the granted requester
//   busy    : arbiter not idle
//   err     : sticky feedback-mismatch flag
interface sr_ctrl_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] op;
  logic             q;
  logic             err_clr;
  logic             S;
  logic             R;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic             busy;
  logic             err;

  modport master (
    output req, op, q, err_clr,
    input  S, R, gnt, done, busy, err
  );

  modport slave (
    input  req, op, q, err_clr,
    output S, R, gnt, done, busy, err
  );
endinterface

// File: rtl/sr_ctrl_arbiter.sv
// sr_ctrl_arbiter -- round-robin arbiter that lets one of N_REQ requesters at a
// time set or clear an external SR flip-flop with a PULSE_W-cycle S/R pulse,
// then checks the flop's feedback.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : sr_ctrl_arbiter_if.slave (req/op/q/err_clr in, S/R/gnt/done/busy/err out)
//
//   state | meaning
//   IDLE  | no operation; winner picked at the edge that leaves IDLE
//   PULSE | S or R driven for PULSE_W cycles, gnt held
//   CHECK | drives released, done pulsed, q compared at the closing edge
//
// All outputs come straight from flops whose next values are derived from the
// next state, so no input reaches an output combinationally.
module sr_ctrl_arbiter #(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  sr_ctrl_arbiter_if.slave  bus
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, PULSE, CHECK} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    ptr, ptr_nx;
  logic [PW-1:0]    win, win_nx;
  logic             op_lat, op_lat_nx;
  logic [3:0]       cnt, cnt_nx;

  logic             s_r, s_nx;
  logic             r_r, r_nx;
  logic [N_REQ-1:0] gnt_r, gnt_nx;
  logic [N_REQ-1:0] done_r, done_nx;
  logic             busy_r, busy_nx;
  logic             err_r, err_nx;

  logic             found;
  logic [PW-1:0]    pick;
  logic [PW-1:0]    idx;

  // Round-robin search starting at ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    win_nx    = win;
    op_lat_nx = op_lat;
    cnt_nx    = cnt;
    err_nx    = err_r;
    if (bus.err_clr) err_nx = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          win_nx    = pick;
          op_lat_nx = bus.op[pick];
          cnt_nx    = 4'(PULSE_W - 1);
          ptr_nx    = PW'((int'(pick) + 1) % N_REQ);
          state_nx  = PULSE;
        end
      end
      PULSE: begin
        if (cnt == 4'd0) state_nx = CHECK;
        else             cnt_nx   = cnt - 4'd1;
      end
      CHECK: begin
        state_nx = IDLE;
        // Set has priority over a coincident err_clr.
        if (bus.q != op_lat) err_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    s_nx    = (state_nx == PULSE) &&  op_lat_nx;
    r_nx    = (state_nx == PULSE) && !op_lat_nx;
    gnt_nx  = (state_nx != IDLE)  ? (N_REQ'(1) << win_nx) : '0;
    done_nx = (state_nx == CHECK) ? (N_REQ'(1) << win_nx) : '0;
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      op_lat <= 1'b0;
      cnt    <= '0;
      s_r    <= 1'b0;
      r_r    <= 1'b0;
      gnt_r  <= '0;
      done_r <= '0;
      busy_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      win    <= win_nx;
      op_lat <= op_lat_nx;
      cnt    <= cnt_nx;
      s_r    <= s_nx;
      r_r    <= r_nx;
      gnt_r  <= gnt_nx;
      done_r <= done_nx;
      busy_r <= busy_nx;
      err_r  <= err_nx;
    end
  end

  assign bus.S    = s_r;
  assign bus.R    = r_r;
  assign bus.gnt  = gnt_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;
  assign bus.err  = err_r;

endmodule

// File: tb/tb_sr_ctrl_arbiter.sv
module tb_sr_ctrl_arbiter;

  logic clk;
  logic rst_n;

  sr_ctrl_arbiter_if #(.N_REQ(4)) m_if ();
  sr_ctrl_arbiter_if #(.N_REQ(4)) f1_if ();
  sr_ctrl_arbiter_if #(.N_REQ(4)) f15_if ();

  sr_ctrl_arbiter #(.N_REQ(4), .PULSE_W(2))  u_dut (.clk(clk), .reset(rst_n), .bus(m_if.slave));
  sr_ctrl_arbiter #(.N_REQ(4), .PULSE_W(1))  u_p1  (.clk(clk), .reset(rst_n), .bus(f1_if.slave));
  sr_ctrl_arbiter #(.N_REQ(4), .PULSE_W(15)) u_p15 (.clk(clk), .reset(rst_n), .bus(f15_if.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] op;
    int         idx;
    logic       sop;
  } vec_t;

  vec_t tbl [7];

  int   n_err = 0;
  int   n_chk = 0;
  logic sq0 = 1'b0, sq1 = 1'b0, sq15 = 1'b0;
  logic tie_en = 1'b0;
  logic rnd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic inv(input string nm, input logic s, input logic r,
                     input logic [3:0] g, input logic [3:0] d);
    chk({nm, "_s_and_r"}, 32'(s & r), 0);
    chk({nm, "_gnt_onehot0"}, 32'($onehot0(g)), 1);
    chk({nm, "_done_match"}, 32'($onehot0(d) && ((d & ~g) == 4'b0)), 1);
  endtask

  // One clock: sample #1 after the edge, update the SRFF models, check invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_if.S) sq0 = 1'b1; else if (m_if.R) sq0 = 1'b0;
    if (f1_if.S) sq1 = 1'b1; else if (f1_if.R) sq1 = 1'b0;
    if (f15_if.S) sq15 = 1'b1; else if (f15_if.R) sq15 = 1'b0;
    m_if.q = tie_en ? 1'b0 : sq0;
    if (rnd) begin
      f1_if.q  = 1'($urandom);
      f15_if.q = 1'($urandom);
    end else begin
      f1_if.q  = sq1;
      f15_if.q = sq15;
    end
    inv("m",   m_if.S,   m_if.R,   m_if.gnt,   m_if.done);
    inv("p1",  f1_if.S,  f1_if.R,  f1_if.gnt,  f1_if.done);
    inv("p15", f15_if.S, f15_if.R, f15_if.gnt, f15_if.done);
  endtask

  task automatic run_op(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.idx;
    m_if.req = v.req;
    m_if.op  = v.op;
    tick();
    chk("op_gnt_pulse", m_if.gnt, oh);
    chk("op_s", m_if.S, v.sop);
    chk("op_r", m_if.R, !v.sop);
    chk("op_done_pulse", m_if.done, 0);
    chk("op_busy", m_if.busy, 1);
    // Changes after the grant must not matter.
    m_if.req = 4'b0000;
    m_if.op  = ~v.op;
    tick();
    chk("op_gnt_pulse2", m_if.gnt, oh);
    chk("op_s2", m_if.S, v.sop);
    chk("op_r2", m_if.R, !v.sop);
    tick();
    chk("op_check_s", m_if.S, 0);
    chk("op_check_r", m_if.R, 0);
    chk("op_check_gnt", m_if.gnt, oh);
    chk("op_check_done", m_if.done, oh);
    tick();
    chk("op_idle_gnt", m_if.gnt, 0);
    chk("op_idle_done", m_if.done, 0);
    chk("op_idle_busy", m_if.busy, 0);
    chk("op_idle_err", m_if.err, 0);
  endtask

  initial begin
    int rc;
    logic seen;

    tbl[0] = '{req: 4'b0100, op: 4'b0100, idx: 2, sop: 1'b1};
    tbl[1] = '{req: 4'b0011, op: 4'b0000, idx: 0, sop: 1'b0};
    tbl[2] = '{req: 4'b0011, op: 4'b0010, idx: 1, sop: 1'b1};
    tbl[3] = '{req: 4'b1001, op: 4'b1000, idx: 3, sop: 1'b1};
    tbl[4] = '{req: 4'b1111, op: 4'b0101, idx: 0, sop: 1'b1};
    tbl[5] = '{req: 4'b1000, op: 4'b0000, idx: 3, sop: 1'b0};
    tbl[6] = '{req: 4'b1010, op: 4'b1010, idx: 1, sop: 1'b1};

    rst_n = 1'b0;
    m_if.req = 4'hF;  m_if.op = 4'hF;  m_if.q = 1'b0;  m_if.err_clr = 1'b0;
    f1_if.req = '0;   f1_if.op = '0;   f1_if.q = 1'b0; f1_if.err_clr = 1'b0;
    f15_if.req = '0;  f15_if.op = '0;  f15_if.q = 1'b0; f15_if.err_clr = 1'b0;

    // Held in reset with all requests up.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_s", m_if.S, 0);
      chk("rst_r", m_if.R, 0);
      chk("rst_gnt", m_if.gnt, 0);
      chk("rst_done", m_if.done, 0);
      chk("rst_busy", m_if.busy, 0);
      chk("rst_err", m_if.err, 0);
    end
    m_if.req = 4'h0;
    rst_n = 1'b1;

    // Fairness: continuous requests, grant order 0,1,2,3,0 with one idle cycle between.
    m_if.req = 4'hF;
    m_if.op  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fair_gnt", m_if.gnt, 32'(4'b0001 << (k % 4)));
      tick();
      tick();
      chk("fair_done", m_if.done, 32'(4'b0001 << (k % 4)));
      tick();
      chk("fair_idle_gnt", m_if.gnt, 0);
      chk("fair_idle_busy", m_if.busy, 0);
    end
    m_if.req = 4'h0;

    // Table of single operations; pointer carries over from the previous row.
    for (int i = 0; i < 7; i++) run_op(tbl[i]);

    // Feedback stuck low during a set: sticky error.
    tie_en = 1'b1;
    m_if.q = 1'b0;
    m_if.req = 4'b0001;
    m_if.op  = 4'b0001;
    tick();
    m_if.req = 4'b0000;
    tick();
    tick();
    chk("err_not_before_check", m_if.err, 0);
    tick();
    chk("err_set", m_if.err, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("err_sticky", m_if.err, 1);
    m_if.err_clr = 1'b1;
    tick();
    m_if.err_clr = 1'b0;
    chk("err_cleared", m_if.err, 0);

    // Mismatch and err_clr at the same edge: set wins.
    m_if.req = 4'b0001;
    tick();
    m_if.req = 4'b0000;
    m_if.err_clr = 1'b1;
    tick();
    tick();
    tick();
    chk("err_set_wins", m_if.err, 1);
    tick();
    chk("err_clr_held", m_if.err, 0);
    m_if.err_clr = 1'b0;
    tie_en = 1'b0;
    m_if.q = sq0;

    // Reset in the middle of a pulse.
    m_if.req = 4'b0001;
    m_if.op  = 4'b0001;
    tick();
    chk("mid_s_before", m_if.S, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_s_async", m_if.S, 0);
    chk("mid_r_async", m_if.R, 0);
    chk("mid_gnt_async", m_if.gnt, 0);
    chk("mid_busy_async", m_if.busy, 0);
    m_if.req = 4'b1010;
    m_if.op  = 4'b1010;
    tick();
    chk("mid_no_done", m_if.done, 0);
    rst_n = 1'b1;
    tick();
    chk("mid_first_gnt", m_if.gnt, 32'(4'b0010));
    chk("mid_first_s", m_if.S, 1);
    m_if.req = 4'b0000;
    tick();
    tick();
    chk("mid_done", m_if.done, 32'(4'b0010));
    tick();
    chk("mid_idle", m_if.busy, 0);

    // PULSE_W = 1: one-cycle drive.
    f1_if.req = 4'b0001;
    f1_if.op  = 4'b0001;
    tick();
    chk("p1_s", f1_if.S, 1);
    chk("p1_gnt", f1_if.gnt, 32'(4'b0001));
    f1_if.req = 4'b0000;
    tick();
    chk("p1_s_off", f1_if.S, 0);
    chk("p1_done", f1_if.done, 32'(4'b0001));
    tick();
    chk("p1_idle", f1_if.busy, 0);

    // PULSE_W = 15: clear pulse length.
    f15_if.req = 4'b1000;
    f15_if.op  = 4'b0000;
    tick();
    f15_if.req = 4'b0000;
    rc = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (f15_if.R) rc++;
      if (f15_if.S) rc += 100;
      if (f15_if.done == 4'b1000) seen = 1'b1;
      tick();
    end
    chk("p15_r_cycles", rc, 15);
    chk("p15_done_seen", seen, 1);
    chk("p15_idle", f15_if.busy, 0);

    // Random traffic on the PULSE_W=1 and PULSE_W=15 instances; invariants checked every tick.
    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      f1_if.req      = 4'($urandom);
      f1_if.op       = 4'($urandom);
      f1_if.err_clr  = 1'($urandom);
      f15_if.req     = 4'($urandom);
      f15_if.op      = 4'($urandom);
      f15_if.err_clr = 1'($urandom);
      tick();
    end
    rnd = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
